adder_tree_accumulator: RTL and testbench

- Downstream consumer of the registered adder-tree sum.
- Accumulates ACC_COUNT consecutive valid sums into one wide result and tracks the peak sum within that window.
- Presents the window result on a valid/ready output register so a slower sink can apply backpressure toward the tree.
- Sits between the adder-tree top and the result sink.

---
 rtl/adder_tree_pkg.sv | 21 ++
 rtl/adder_tree_acc_out_reg.sv | 44 ++++
 rtl/adder_tree_accumulator.sv | 87 ++++++++
 tb/tb_adder_tree_accumulator.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_tree_pkg.sv
// Shared sizing helpers and result payload type for the adder-tree accumulator.
package adder_tree_pkg;

  localparam int ADDER_WIDTH_DEF = 9;
  localparam int ACC_COUNT_DEF   = 16;

  function automatic int cnt_width(input int count);
    return $clog2(count);
  endfunction

  // Window total is exact: ACC_COUNT sums of ADDER_WIDTH+1 bits never overflow.
  function automatic int acc_width(input int adder_width, input int count);
    return adder_width + 1 + cnt_width(count);
  endfunction

  typedef struct packed {
    logic [acc_width(ADDER_WIDTH_DEF, ACC_COUNT_DEF)-1:0] acc;
    logic [ADDER_WIDTH_DEF:0]                             peak;
  } acc_result_t;

endpackage

// File: rtl/adder_tree_acc_out_reg.sv
// Single-entry valid/ready holding register: load wins over drain, holds otherwise.
module adder_tree_acc_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             ready_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  // Slot is free when empty or being drained this cycle.
  assign ready_o = !valid_q || ready_i;

endmodule

// File: rtl/adder_tree_accumulator.sv
// Sums ACC_COUNT consecutive tree results per window and tracks the window peak.
module adder_tree_accumulator
  import adder_tree_pkg::*;
#(
  parameter  int ADDER_WIDTH = 9,
  parameter  int ACC_COUNT   = 16,
  localparam int CNT_W       = cnt_width(ACC_COUNT),
  localparam int ACC_W       = acc_width(ADDER_WIDTH, ACC_COUNT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [ADDER_WIDTH:0] sum_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [ACC_W-1:0]   acc_out,
  output logic [ADDER_WIDTH:0] peak_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   win_cnt
);

  typedef struct packed {
    logic [ACC_W-1:0]     acc;
    logic [ADDER_WIDTH:0] peak;
  } result_t;

  logic [ACC_W-1:0]     acc_q, acc_d, acc_next;
  logic [ADDER_WIDTH:0] peak_q, peak_d, peak_next;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 accept, last_beat;
  result_t              res_in, res_out;

  // A beat offered alongside flush is dropped.
  assign accept    = in_valid && in_ready && !flush;
  assign last_beat = (cnt_q == CNT_W'(ACC_COUNT - 1));
  assign acc_next  = acc_q + ACC_W'(sum_in);
  assign peak_next = (sum_in > peak_q) ? sum_in : peak_q;

  always_comb begin
    acc_d  = acc_q;
    peak_d = peak_q;
    cnt_d  = cnt_q;
    if (flush || (accept && last_beat)) begin
      acc_d  = '0;
      peak_d = '0;
      cnt_d  = '0;
    end else if (accept) begin
      acc_d  = acc_next;
      peak_d = peak_next;
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      peak_q <= '0;
      cnt_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      peak_q <= peak_d;
      cnt_q  <= cnt_d;
    end
  end

  assign res_in.acc  = acc_next;
  assign res_in.peak = peak_next;

  adder_tree_acc_out_reg #(
    .WIDTH($bits(result_t))
  ) u_out_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (accept && last_beat),
    .data_i  (res_in),
    .ready_i (out_ready),
    .valid_o (out_valid),
    .data_o  (res_out),
    .ready_o (in_ready)
  );

  assign acc_out  = res_out.acc;
  assign peak_out = res_out.peak;
  assign win_cnt  = cnt_q;

endmodule

// File: tb/tb_adder_tree_accumulator.sv
// Randomised and directed checks of adder_tree_accumulator against a queue-based window model.
module tb_adder_tree_accumulator;

  localparam int AW   = 9;
  localparam int N    = 4;
  localparam int CW   = 2;
  localparam int ACCW = 12;
  localparam int VW   = 1 + ACCW + AW + 1 + CW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW:0]   sum_in = '0;
  logic          in_ready, out_valid;
  logic [ACCW-1:0] acc_out;
  logic [AW:0]   peak_out;
  logic [CW-1:0] win_cnt;
  logic [VW-1:0] dut_vec;

  int vectors = 0;
  int miscompares = 0;

  int q_beats[$];
  bit m_valid;
  int m_acc, m_peak;
  bit exp_rdy, obs_rdy;

  always #5 clk = ~clk;

  adder_tree_accumulator #(.ADDER_WIDTH(AW), .ACC_COUNT(N)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .sum_in(sum_in), .in_valid(in_valid),
    .in_ready(in_ready), .acc_out(acc_out), .peak_out(peak_out), .out_valid(out_valid),
    .out_ready(out_ready), .win_cnt(win_cnt)
  );

  assign dut_vec = {out_valid, acc_out, peak_out, win_cnt};

  function automatic logic [VW-1:0] model_vec();
    int c;
    c = q_beats.size();
    return {m_valid, ACCW'(m_acc), 10'(m_peak), CW'(c)};
  endfunction

  function automatic void model_clear();
    q_beats.delete();
    m_valid = 1'b0;
    m_acc   = 0;
    m_peak  = 0;
  endfunction

  // One clock: apply inputs after negedge, sample in_ready, advance model at posedge.
  task automatic drive(input bit f, input bit v, input int s, input bit r);
    int sv, tot, mx;
    bit hs, acc;
    sv = s & 1023;
    flush = f; in_valid = v; sum_in = 10'(sv); out_ready = r;
    #1;
    obs_rdy = in_ready;
    exp_rdy = !m_valid || r;
    @(posedge clk);
    hs  = m_valid && r;
    acc = v && exp_rdy && !f;
    if (f) q_beats.delete();
    else if (acc) q_beats.push_back(sv);
    if (acc && q_beats.size() == N) begin
      tot = 0; mx = 0;
      foreach (q_beats[k]) begin
        tot += q_beats[k];
        if (q_beats[k] > mx) mx = q_beats[k];
      end
      m_acc = tot; m_peak = mx; m_valid = 1'b1;
      q_beats.delete();
    end else if (hs) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    vectors++;
    if (dut_vec !== '0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset: got rdy=%b vec=%h, want rdy=1 vec=0", in_ready, dut_vec);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int s[4] = '{10, 20, 30, 40};
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, s[i], 1);
      vectors++;
      if (obs_rdy !== exp_rdy || dut_vec !== model_vec()) begin
        miscompares++;
        $display("FAIL basic beat%0d: got rdy=%b vec=%h, want rdy=%b vec=%h", i, obs_rdy, dut_vec, exp_rdy, model_vec());
      end
    end
    vectors++;
    if (out_valid !== 1'b1 || acc_out !== 12'd100 || peak_out !== 10'd40 || win_cnt !== 2'd0) begin
      miscompares++;
      $display("FAIL basic result: got v=%b acc=%0d peak=%0d cnt=%0d, want v=1 acc=100 peak=40 cnt=0", out_valid, acc_out, peak_out, win_cnt);
    end
    drive(0, 0, 0, 1);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic one_cycle: got out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int results = 0;
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 1023, 1);
      vectors++;
      if (obs_rdy !== 1'b1 || dut_vec !== model_vec()) begin
        miscompares++;
        $display("FAIL b2b beat%0d: got rdy=%b vec=%h, want rdy=1 vec=%h", i, obs_rdy, dut_vec, model_vec());
      end
      if (out_valid === 1'b1) begin
        results++;
        vectors++;
        if (acc_out !== 12'd4092 || peak_out !== 10'd1023) begin
          miscompares++;
          $display("FAIL b2b result: got acc=%0d peak=%0d, want acc=4092 peak=1023", acc_out, peak_out);
        end
      end
    end
    vectors++;
    if (results != 2) begin
      miscompares++;
      $display("FAIL b2b count: got %0d results, want 2", results);
    end
    drive(0, 0, 0, 1);
  endtask

  task automatic test_backpressure();
    logic [ACCW-1:0] held;
    int pend;
    for (int i = 0; i < 4; i++) drive(0, 1, $urandom_range(0, 1023), 1);
    held = acc_out;
    for (int i = 0; i < 5; i++) begin
      pend = $urandom_range(0, 1023);
      drive(0, 1, pend, 0);
      vectors++;
      if (obs_rdy !== 1'b0 || acc_out !== held || out_valid !== 1'b1 || dut_vec !== model_vec()) begin
        miscompares++;
        $display("FAIL backpressure hold%0d: got rdy=%b v=%b acc=%0d, want rdy=0 v=1 acc=%0d", i, obs_rdy, out_valid, acc_out, held);
      end
    end
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, $urandom_range(0, 1023), 1);
      vectors++;
      if (obs_rdy !== exp_rdy || dut_vec !== model_vec()) begin
        miscompares++;
        $display("FAIL backpressure resume%0d: got rdy=%b vec=%h, want rdy=%b vec=%h", i, obs_rdy, dut_vec, exp_rdy, model_vec());
      end
    end
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
  endtask

  task automatic test_flush();
    int s[7] = '{5, 7, 9, 1, 2, 3, 4};
    for (int i = 0; i < 7; i++) begin
      drive(i == 2, 1, s[i], 1);
      vectors++;
      if (obs_rdy !== exp_rdy || dut_vec !== model_vec()) begin
        miscompares++;
        $display("FAIL flush step%0d: got rdy=%b vec=%h, want rdy=%b vec=%h", i, obs_rdy, dut_vec, exp_rdy, model_vec());
      end
    end
    vectors++;
    if (out_valid !== 1'b1 || acc_out !== 12'd10 || peak_out !== 10'd4) begin
      miscompares++;
      $display("FAIL flush result: got v=%b acc=%0d peak=%0d, want v=1 acc=10 peak=4", out_valid, acc_out, peak_out);
    end
    drive(0, 0, 0, 1);
  endtask

  task automatic test_flush_pending();
    int s[4] = '{100, 200, 300, 50};
    for (int i = 0; i < 4; i++) drive(0, 1, s[i], 1'(i < 3));
    drive(0, 0, 0, 0);
    drive(1, 1, 77, 0);
    vectors++;
    if (out_valid !== 1'b1 || acc_out !== 12'd650 || peak_out !== 10'd300 || win_cnt !== 2'd0) begin
      miscompares++;
      $display("FAIL flush_pending held: got v=%b acc=%0d peak=%0d cnt=%0d, want v=1 acc=650 peak=300 cnt=0", out_valid, acc_out, peak_out, win_cnt);
    end
    drive(0, 0, 0, 1);
    vectors++;
    if (out_valid !== 1'b0 || dut_vec !== model_vec()) begin
      miscompares++;
      $display("FAIL flush_pending drain: got vec=%h, want %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_zero();
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 1);
    vectors++;
    if (out_valid !== 1'b1 || acc_out !== 12'd0 || peak_out !== 10'd0) begin
      miscompares++;
      $display("FAIL zero result: got v=%b acc=%0d peak=%0d, want v=1 acc=0 peak=0", out_valid, acc_out, peak_out);
    end
    drive(0, 0, 0, 1);
  endtask

  task automatic test_mid_reset();
    drive(0, 1, 3, 1);
    drive(0, 1, 6, 1);
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    vectors++;
    if (dut_vec !== '0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset window: got rdy=%b vec=%h, want rdy=1 vec=0", in_ready, dut_vec);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) drive(0, 1, 500, 1'(i < 3));
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    vectors++;
    if (dut_vec !== '0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset pending: got rdy=%b vec=%h, want rdy=1 vec=0", in_ready, dut_vec);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) drive(0, 1, 1, 1);
    vectors++;
    if (out_valid !== 1'b1 || acc_out !== 12'd4 || peak_out !== 10'd1) begin
      miscompares++;
      $display("FAIL mid_reset fresh: got v=%b acc=%0d peak=%0d, want v=1 acc=4 peak=1", out_valid, acc_out, peak_out);
    end
    drive(0, 0, 0, 1);
  endtask

  task automatic test_random();
    int s, pick;
    for (int i = 0; i < 400; i++) begin
      pick = $urandom_range(0, 3);
      s = (pick == 0) ? 0 : (pick == 1) ? 1023 : $urandom_range(0, 1023);
      drive(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) != 0), s, 1'($urandom_range(0, 2) != 0));
      vectors++;
      if (obs_rdy !== exp_rdy || dut_vec !== model_vec()) begin
        miscompares++;
        $display("FAIL random cyc%0d: got rdy=%b vec=%h, want rdy=%b vec=%h", i, obs_rdy, dut_vec, exp_rdy, model_vec());
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_flush_pending();
    test_zero();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
